// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Multi-cycle subtractor computing (a - b - bin) mod 2^WIDTH over unsigned
//   operands. DIGIT bits are processed per RUN cycle, LSB slice first, with a
//   ripple borrow register carried from one slice to the next. Operands are
//   accepted and results delivered through valid/ready handshakes.
//
// Parameters:
//   WIDTH - operand/result width in bits (integer multiple of DIGIT)
//   DIGIT - bits processed per RUN cycle (1 <= DIGIT <= WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   operands a, b, bin valid
//   in_ready   block can accept operands (high only in IDLE)
//   a          minuend
//   b          subtrahend
//   bin        borrow-in
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   diff       (a - b - bin) mod 2^WIDTH, registered
//   bout       borrow-out, 1 iff a < b + bin (unsigned), registered
//   ovf        signed overflow of a - b - bin (only with SERIAL_SUB_OVF_EN)
//
// Optional feature macro:
//   SERIAL_SUB_OVF_EN - adds the ovf output and the operand MSB capture
//                       registers it needs.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    // Keep the counter at least one bit wide so DIGIT == WIDTH still elaborates.
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;
    logic [DIGIT:0]     slice_wide;
    logic [DIGIT-1:0]   slice;
    logic               brw_n;

    // One DIGIT-wide subtract per cycle. Doing it at DIGIT+1 bits makes the
    // extra MSB the borrow-out of the slice, since the magnitude of a negative
    // result never exceeds 2^DIGIT.
    always_comb begin
        slice_a    = a_q[DIGIT-1:0];
        slice_b    = b_q[DIGIT-1:0];
        slice_wide = {1'b0, slice_a} - {1'b0, slice_b} - (DIGIT+1)'(brw_q);
        slice      = slice_wide[DIGIT-1:0];
        brw_n      = slice_wide[DIGIT];
    end

    // Next-state and handshake outputs. The result register fills from the
    // top: each new slice enters at the MSB end and older slices move down,
    // so after STEPS cycles the first (least significant) slice sits at bit 0.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                end
            end

            RUN: begin
                res_d = (res_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = brw_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // Operands of differing sign whose result sign differs
                    // from the minuend's: two's-complement overflow.
                    ovf_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, so a result that
    // was in flight is dropped and never presented after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Result outputs come straight from registers and are untouched while
    // DONE waits for out_ready.
    assign diff = res_q;
    assign bout = brw_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
